// File: rtl/seq_right_shifter.sv
// Iterative right shifter: one bit position per clock, one-hot shift amount,
// logical / arithmetic / rotate modes, with done/err completion pulses.
module seq_right_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] sel,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, ERR} state_t;
  typedef enum logic [1:0] {M_LOG = 2'b00, M_ARI = 2'b01, M_ROT = 2'b10, M_RSV = 2'b11} mode_t;

  state_t           state_q;
  mode_t            mode_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] dout_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [CW-1:0]    sel_idx;
  int unsigned      sel_ones;
  logic             req_ok;
  logic             fill_d;
  logic [WIDTH-1:0] shift_d;

  always_comb begin
    sel_idx  = '0;
    sel_ones = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sel[i]) begin
        sel_idx  = CW'(i);
        sel_ones = sel_ones + 1;
      end
    end
    req_ok = (sel_ones == 1) && (mode != M_RSV);
  end

  // The MSB never changes during an arithmetic shift, so data_q's MSB is the captured sign.
  always_comb begin
    fill_d = 1'b0;
    case (mode_q)
      M_ARI:   fill_d = data_q[WIDTH-1];
      M_ROT:   fill_d = data_q[0];
      default: fill_d = 1'b0;
    endcase
    shift_d = {fill_d, data_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= M_LOG;
      data_q  <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (req_ok) begin
              data_q <= din;
              mode_q <= mode_t'(mode);
              cnt_q  <= sel_idx;
              if (sel_idx == '0) begin
                state_q <= DONE;
                dout_q  <= din;
                done_q  <= 1'b1;
              end else begin
                state_q <= SHIFT;
              end
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          data_q <= shift_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            dout_q  <= shift_d;
            done_q  <= 1'b1;
          end
        end
        DONE, ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Bench for seq_right_shifter: vector table plus random ops, scoreboard queue
// checked whenever done or err pulses.
module tb_seq_right_shifter;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] sel;
    logic [1:0]   mode;
    logic [W-1:0] exp_dout;
    logic         exp_err;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] dout;
    logic         err;
    int           cyc;
    int           lat;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] sel = '0;
  logic [1:0]   mode = '0;
  logic [W-1:0] dout;
  logic         busy, done, err;

  int  n_cmp = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  busy_run = 0;
  sb_t sb[$];

  seq_right_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .sel(sel), .mode(mode),
    .dout(dout), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int n, input logic [1:0] m);
    logic signed [W-1:0] sd;
    logic [2*W-1:0]      dd;
    sd = d;
    dd = {d, d} >> n;
    case (m)
      2'b00:   return d >> n;
      2'b01:   return sd >>> n;
      default: return dd[W-1:0];
    endcase
  endfunction

  // Scoreboard: every completion pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      else busy_run = 0;
      if (done || err) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b with no request outstanding", done, err);
        end else begin
          e = sb.pop_front();
          check("err_flag", 32'(err), 32'(e.err));
          check("done_flag", 32'(done), 32'(!e.err));
          check("dout", 32'(dout), 32'(e.dout));
          check("latency_cycle", cyc, e.cyc + e.lat);
          check("busy_length", busy_run, e.lat + 1);
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b expected 0", busy);
    end
  endtask

  task automatic issue(input logic [W-1:0] d, input logic [W-1:0] s, input logic [1:0] m,
                       input logic [W-1:0] exp_dout, input logic exp_err, input int lat);
    sb_t e;
    wait_idle();
    din = d; sel = s; mode = m; start = 1'b1;
    @(posedge clk);
    #1;
    e.dout = exp_dout; e.err = exp_err; e.cyc = cyc; e.lat = lat;
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL completion_timeout: %0d requests outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    vec_t vecs[$];
    logic [W-1:0] rd, rs;
    logic [1:0]   rm;
    int           rn, k;
    sb_t          e;

    vecs.push_back('{4'b1011, 4'b0001, 2'b00, 4'b1011, 1'b0, 0});
    vecs.push_back('{4'b1011, 4'b0100, 2'b00, 4'b0010, 1'b0, 2});
    vecs.push_back('{4'b1011, 4'b1000, 2'b01, 4'b1111, 1'b0, 3});
    vecs.push_back('{4'b0110, 4'b1000, 2'b01, 4'b0000, 1'b0, 3});
    vecs.push_back('{4'b1011, 4'b0010, 2'b10, 4'b1101, 1'b0, 1});
    vecs.push_back('{4'b1011, 4'b0110, 2'b00, 4'b1101, 1'b1, 0});
    vecs.push_back('{4'b1011, 4'b0100, 2'b11, 4'b1101, 1'b1, 0});
    vecs.push_back('{4'b1011, 4'b0000, 2'b00, 4'b1101, 1'b1, 0});
    vecs.push_back('{4'b1001, 4'b0100, 2'b10, 4'b0110, 1'b0, 2});
    vecs.push_back('{4'b1000, 4'b0010, 2'b01, 4'b1100, 1'b0, 1});
    vecs.push_back('{4'b0111, 4'b0001, 2'b11, 4'b1100, 1'b1, 0});
    vecs.push_back('{4'b1111, 4'b1000, 2'b00, 4'b0001, 1'b0, 3});

    // Asynchronous reset with no clock edge in between.
    #3 rst = 1'b1;
    #1;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_dout", 32'(dout), 32'h0);

    foreach (vecs[i]) begin
      issue(vecs[i].din, vecs[i].sel, vecs[i].mode, vecs[i].exp_dout, vecs[i].exp_err, vecs[i].lat);
      drain();
    end

    // Back-to-back: second start raised in the done cycle, sampled once back in IDLE.
    issue(4'b1011, 4'b0010, 2'b10, 4'b1101, 1'b0, 1);
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b2b_first_done", 32'(done), 32'h1);
    din = 4'b1011; sel = 4'b0100; mode = 2'b10; start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    e.dout = 4'b1110; e.err = 1'b0; e.cyc = cyc; e.lat = 2;
    sb.push_back(e);
    start = 1'b0;
    drain();

    // start pulses and input changes while busy must be ignored.
    issue(4'b1011, 4'b1000, 2'b00, 4'b0001, 1'b0, 3);
    @(negedge clk);
    start = 1'b1; din = 4'b0101; sel = 4'b0001; mode = 2'b01;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    check("ignored_start_busy", 32'(busy), 32'h0);

    // Reset mid-shift discards the operation.
    issue(4'b1011, 4'b1000, 2'b01, 4'b1111, 1'b0, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_dout", 32'(dout), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("postrst_dout", 32'(dout), 32'h0);
    issue(4'b1100, 4'b0100, 2'b01, 4'b1111, 1'b0, 2);
    drain();

    for (int i = 0; i < 20; i++) begin
      rd = 4'($urandom);
      rn = $urandom_range(0, W - 1);
      rm = 2'($urandom_range(0, 2));
      rs = 4'(1) << rn;
      issue(rd, rs, rm, model(rd, rn, rm), 1'b0, rn);
      drain();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
